// File: rtl/tt_ranword_gen_if.sv
// tt_ranword_gen_if: read-side valid/ready handshake for the random word stream.
interface tt_ranword_gen_if #(parameter int WORD_W = 8) ();
    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;
    modport master (output rd_valid, rd_data, input rd_ready);
    modport slave (input rd_valid, rd_data, output rd_ready);
endinterface

// File: rtl/tt_ranword_gen.sv
// tt_ranword_gen: ring-oscillator TRNG with LFSR whitening, repetition-count health test and word assembly.
// Optional von Neumann debiaser enabled by defining VN_DEBIAS_EN.
module tt_ranword_gen #(
    parameter int NCH       = 3,
    parameter int WORD_W    = 8,
    parameter int RCT_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [NCH-1:0]   ring_bits,
    input  logic             whiten_en,
    tt_ranword_gen_if.master rd,
    output logic             overrun,
    output logic             health_fail
);
    localparam int CW = $clog2(WORD_W + 1);
    typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;
    state_t            state_q, state_d;
    logic [NCH-1:0]    s1_q, s2_q;
    logic              raw_q, prev_q;
    logic [15:0]       lfsr_q;
    logic [7:0]        rc_q, rc_d;
    logic [WORD_W-1:0] asm_q, asm_d, rd_data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rd_valid_q, valid_d, overrun_q, health_fail_q;
    logic              run, trip, acc_v, acc_b, bit_in, full, done, load, drop;
    assign run = state_q == RUN;
`ifdef VN_DEBIAS_EN
    logic vn_have_q, vn_first_q;
    // Second bit of a pair yields a bit only when it differs from the first.
    assign acc_v = run && vn_have_q && (vn_first_q != raw_q);
    assign acc_b = vn_first_q;
`else
    assign acc_v = run;
    assign acc_b = raw_q;
`endif
    always_comb begin
        rc_d    = (rc_q == 8'd0 || raw_q != prev_q) ? 8'd1 : rc_q + 8'd1;
        trip    = run && rc_d == 8'(RCT_LIMIT);
        bit_in  = acc_b ^ (whiten_en & lfsr_q[0]);
        full    = cnt_q == CW'(WORD_W);
        asm_d   = acc_v ? {asm_q[WORD_W-2:0], bit_in} : asm_q;
        cnt_d   = (!enable || trip) ? '0 : full ? CW'(acc_v) : cnt_q + CW'(acc_v);
        done    = run && full && !trip;
        load    = done && (!rd_valid_q || rd.rd_ready);
        drop    = done && rd_valid_q && !rd.rd_ready;
        valid_d = trip ? 1'b0 : load ? 1'b1 : rd_valid_q && !rd.rd_ready;
        data_d  = load ? asm_q : rd_data_q;
        state_d = trip ? FAIL : (run && !enable) ? IDLE : (state_q == IDLE && enable) ? RUN : state_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            s1_q          <= '0;
            s2_q          <= '0;
            raw_q         <= 1'b0;
            prev_q        <= 1'b0;
            lfsr_q        <= 16'hACE1;
            rc_q          <= '0;
            asm_q         <= '0;
            cnt_q         <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            health_fail_q <= 1'b0;
`ifdef VN_DEBIAS_EN
            vn_have_q     <= 1'b0;
            vn_first_q    <= 1'b0;
`endif
        end else begin
            s1_q          <= ring_bits;
            s2_q          <= s1_q;
            raw_q         <= ^s2_q;
            state_q       <= state_d;
            rd_valid_q    <= valid_d;
            rd_data_q     <= data_d;
            overrun_q     <= overrun_q | drop;
            health_fail_q <= health_fail_q | trip;
            if (run) begin
                lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                rc_q   <= rc_d;
                prev_q <= raw_q;
                asm_q  <= asm_d;
                cnt_q  <= cnt_d;
`ifdef VN_DEBIAS_EN
                vn_have_q  <= enable && !trip && !vn_have_q;
                vn_first_q <= raw_q;
`endif
            end
        end
    end
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign overrun     = overrun_q;
    assign health_fail = health_fail_q;
endmodule

// File: tb/tb_tt_ranword_gen.sv
// tb_tt_ranword_gen: directed checks of reset, raw/whitened words, overrun, enable drop and health trip.
module tb_tt_ranword_gen;
    logic       clk = 1'b0;
    logic       rst, enable, whiten_en, overrun, health_fail;
    logic [2:0] ring_bits;
    int         checks = 0;
    int         failures = 0;
    tt_ranword_gen_if #(.WORD_W(8)) rd_if ();
    tt_ranword_gen #(.NCH(3), .WORD_W(8), .RCT_LIMIT(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ring_bits(ring_bits), .whiten_en(whiten_en),
        .rd(rd_if.master), .overrun(overrun), .health_fail(health_fail)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Random channel mix whose XOR equals the wanted raw bit.
    task automatic drive_bit(input logic b);
        logic [1:0] r;
        r = 2'($urandom_range(0, 3));
        ring_bits = {r[1], r[0], b ^ r[1] ^ r[0]};
        @(negedge clk);
    endtask
    task automatic cycle(input int k);
        for (int i = 0; i < k; i++) drive_bit(i[0]);
    endtask
    task automatic feed(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 2) enable = 1'b1;
            drive_bit(w[n-1-i]);
        end
    endtask
    task automatic do_reset(input string tag);
        rst = 1'b1;
        enable = 1'b0;
        whiten_en = 1'b0;
        rd_if.rd_ready = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(rd_if.rd_valid), 0);
        chk({tag, "_data"}, 32'(rd_if.rd_data), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_hf"}, 32'(health_fail), 0);
        chk({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'hACE1);
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic consume();
        enable = 1'b0;
        rd_if.rd_ready = 1'b1;
        cycle(1);
        rd_if.rd_ready = 1'b0;
    endtask
    initial begin
        ring_bits = '0;
        rst = 1'b1;
        @(negedge clk);
        do_reset("rst0");
`ifdef VN_DEBIAS_EN
        feed(32'h78787878, 32);
        cycle(2);
        chk("vn_valid", 32'(rd_if.rd_valid), 1);
        chk("vn_data", 32'(rd_if.rd_data), 32'h55);
        consume();
        chk("vn_consumed", 32'(rd_if.rd_valid), 0);
`else
        feed(32'hB2, 8);
        cycle(3);
        chk("raw_early", 32'(rd_if.rd_valid), 0);
        cycle(1);
        chk("raw_valid", 32'(rd_if.rd_valid), 1);
        chk("raw_data", 32'(rd_if.rd_data), 32'hB2);
        consume();
        chk("raw_consumed", 32'(rd_if.rd_valid), 0);
        feed(32'hC53A, 16);
        cycle(3);
        chk("ovr_before", 32'(overrun), 0);
        cycle(1);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_data", 32'(rd_if.rd_data), 32'hC5);
        chk("ovr_valid", 32'(rd_if.rd_valid), 1);
        enable = 1'b0;
        cycle(1);
        consume();
        chk("ovr_consumed", 32'(rd_if.rd_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        feed(32'h3C, 8);
        cycle(4);
        chk("mid_valid", 32'(rd_if.rd_valid), 1);
        chk("mid_data", 32'(rd_if.rd_data), 32'h3C);
        cycle(2);
        do_reset("rst_mid");
        whiten_en = 1'b1;
        feed(32'hB2, 8);
        cycle(4);
        chk("wht_valid", 32'(rd_if.rd_valid), 1);
        chk("wht_data", 32'(rd_if.rd_data), 32'h35);
        whiten_en = 1'b0;
        consume();
        feed(32'h13, 5);
        cycle(3);
        enable = 1'b0;
        feed(32'hA6, 8);
        cycle(3);
        chk("drop_early", 32'(rd_if.rd_valid), 0);
        cycle(1);
        chk("drop_valid", 32'(rd_if.rd_valid), 1);
        chk("drop_data", 32'(rd_if.rd_data), 32'hA6);
`endif
        do_reset("rst_hc");
        enable = 1'b1;
        ring_bits = 3'b000;
        @(negedge clk);
        repeat (31) @(negedge clk);
        chk("hc_before", 32'(health_fail), 0);
        chk("hc_valid_before", 32'(rd_if.rd_valid), 1);
        @(negedge clk);
        chk("hc_trip", 32'(health_fail), 1);
        chk("hc_valid_off", 32'(rd_if.rd_valid), 0);
        rd_if.rd_ready = 1'b1;
        cycle(20);
        rd_if.rd_ready = 1'b0;
        cycle(2);
        chk("hc_hold", 32'(health_fail), 1);
        chk("hc_valid_hold", 32'(rd_if.rd_valid), 0);
        do_reset("rst_end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tt_ranword_gen.md
TT_RANWORD_GEN -- requirements
Module: tt_ranword_gen

Interface
REQ-001 SHALL have parameter NCH, default 3: number of ring-oscillator entropy channels, 1..8.
REQ-002 SHALL have parameter WORD_W, default 8: output word width in bits, 2..16.
REQ-003 SHALL have parameter RCT_LIMIT, default 32: repetition-count health cutoff, 4..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1: 1 = collect entropy, 0 = idle.
REQ-007 SHALL have port ring_bits, input, NCH: raw, asynchronous ring-oscillator outputs.
REQ-008 SHALL have port whiten_en, input, 1: 1 = XOR accepted bits with LFSR output.
REQ-009 SHALL have port rd_ready, input, 1: the consumer accepts rd_data.
REQ-010 SHALL have port rd_valid, output, 1: rd_data holds an unread word.
REQ-011 SHALL have port rd_data, output, WORD_W: the random word.
REQ-012 SHALL have port overrun, output, 1: sticky flag; a completed word was dropped.
REQ-013 SHALL have port health_fail, output, 1: sticky flag; the repetition-count test tripped.

Function
REQ-014 SHALL pass each ring_bits channel through a 2-flop synchroniser, then XOR-reduce the channels into raw_bit, registered; raw_bit reflects ring_bits sampled 3 edges earlier.
REQ-015 SHALL run a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle while state = RUN; bit 0 is the whitening bit.
REQ-016 SHALL have the states IDLE, RUN and FAIL; IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->FAIL on a health trip; FAIL exits only on rst.
REQ-017 SHALL, in RUN, form the accepted bit per REQ-032 and REQ-033, then XOR it with the LFSR bit 0 when whiten_en=1.
REQ-018 SHALL shift each accepted bit into the assembly register at the LSB (shift left), so the first bit ends at the MSB, and increment bit_cnt.
REQ-019 SHALL, when bit_cnt reaches WORD_W, do the following on the next edge: load rd_data, set rd_valid=1, clear bit_cnt.
REQ-020 SHALL complete a transfer on an edge where rd_valid=1 and rd_ready=1; rd_valid then falls on that edge.
REQ-021 SHALL, when a transfer and a word completion happen on the same edge, load the new word and keep rd_valid=1.
REQ-022 SHALL, when a word completes while rd_valid=1 and rd_ready=0, drop the new word, leave rd_data unchanged and set overrun=1.
REQ-023 SHALL, on RUN->IDLE, discard the partial word (bit_cnt=0 and the von Neumann pair cleared); a pending rd_valid word is kept.
REQ-024 SHALL count consecutive equal raw_bit values while in RUN; a value change reloads the count to 1.
REQ-025 SHALL, when the count reaches RCT_LIMIT, set health_fail=1, enter FAIL and force rd_valid=0.
REQ-026 SHALL, in FAIL, hold rd_data, stop the LFSR and stop word assembly.
REQ-027 SHALL leave the LFSR state and the repetition count unchanged while in IDLE.

Reset
REQ-028 SHALL, on rst=1, asynchronously set state=IDLE, rd_valid=0, rd_data=0, overrun=0, health_fail=0.
REQ-029 SHALL, on rst=1, asynchronously set LFSR=16'hACE1, bit_cnt=0, repetition count=0, and clear the von Neumann pair and synchroniser flops.
REQ-030 SHALL take effect at any time, including mid-word and in FAIL.
REQ-031 SHALL, after rst falls, enter RUN on the first edge with enable=1.

Configuration
REQ-032 SHALL, with macro VN_DEBIAS_EN defined, pair successive raw_bits: 01 gives accepted 0, 10 gives accepted 1, 00 and 11 give no bit; pairs do not overlap, so at most one accepted bit per 2 cycles.
REQ-033 SHALL, with VN_DEBIAS_EN undefined, accept raw_bit every RUN cycle and contain no debiaser logic; the health test always uses raw_bit, not the debiased bit.

Verification
REQ-034 SHALL cover reset: assert rst mid-word with rd_valid=1 -> rd_valid=0, rd_data=0, overrun=0, health_fail=0, LFSR=16'hACE1 immediately.
REQ-035 SHALL cover raw words (no macro, whiten_en=0, NCH=3, WORD_W=8): raw_bit sequence 1,0,1,1,0,0,1,0 -> rd_data=8'hB2 and rd_valid=1 one edge after the 8th bit.
REQ-036 SHALL cover debiasing (VN_DEBIAS_EN defined): raw pairs 01,11,10,00 repeated 4 times -> accepted bits 0,1,0,1,0,1,0,1 -> rd_data=8'h55.
REQ-037 SHALL cover overrun: rd_ready=0 while 16 bits are collected -> rd_data = the first word, overrun=1; then rd_ready=1 for one cycle -> rd_valid=0, overrun stays 1.
REQ-038 SHALL cover the health test: ring_bits held at 3'b000 for RCT_LIMIT=32 RUN cycles -> health_fail=1, rd_valid=0; both hold until rst even when ring_bits toggle again.
REQ-039 SHALL cover an enable drop: enable=0 after 5 bits, then enable=1 -> the next word is built only from the 8 bits accepted after re-enable.
